// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM encoding, requester IDs and the RAM
// request payload used by the mem_arbiter block.
package mem_arbiter_pkg;

    localparam int unsigned BUS_WIDTH = 64;
    localparam int unsigned CNT_W     = 4;

    localparam logic [BUS_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_RESP_IF = 2'd1,
        ARB_RESP_LS = 2'd2
    } arb_state_e;

    localparam logic ARB_ID_IF = 1'b0;
    localparam logic ARB_ID_LS = 1'b1;

    // One RAM access as presented on the shared data port.
    typedef struct packed {
        logic                 rd_en;
        logic                 wr_en;
        logic [BUS_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0] wmask;
        logic [BUS_WIDTH-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational grant policy for mem_arbiter.
// Macro MEM_ARB_RR_EN selects round-robin (last_grant input); otherwise
// fixed LS priority with a starvation limit (starve_cnt input).
// Ports: if_valid, ls_valid, state in; last_grant or starve_cnt in;
//        grant_if, grant_ls out (at most one set, only in ARB_IDLE).
module mem_arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             if_valid,
    input  logic             ls_valid,
    input  arb_state_e       state,
`ifdef MEM_ARB_RR_EN
    input  logic             last_grant,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_if,
    output logic             grant_ls
);

    // Uncontended requests win outright; contention goes to the policy.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == ARB_IDLE) begin
            if (if_valid && ls_valid) begin
`ifdef MEM_ARB_RR_EN
                if (last_grant == ARB_ID_IF) grant_ls = 1'b1;
                else                         grant_if = 1'b1;
`else
                if (starve_cnt == CNT_W'(STARVE_MAX)) grant_if = 1'b1;
                else                                  grant_ls = 1'b1;
`endif
            end else begin
                grant_if = if_valid;
                grant_ls = ls_valid;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM data port between the instruction-fetch (IF)
// and load/store (LS) requesters. Each access is an issue cycle followed by
// a response cycle. Macro MEM_ARB_RR_EN switches the contention policy from
// LS-priority-with-starvation-limit to round-robin.
// Ports: clk, rst (async, active-high); IF req valid/ready/addr and rsp
//        valid/data; LS req valid/ready/we/addr/wmask/wdata and rsp
//        valid/data; RAM rd_en/wr_en/addr/wmask/wr_data out, rd_data in.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [BUS_WIDTH-1:0] if_req_addr,
    output logic                 if_rsp_valid,
    output logic [BUS_WIDTH-1:0] if_rsp_data,
    input  logic                 ls_req_valid,
    output logic                 ls_req_ready,
    input  logic                 ls_req_we,
    input  logic [BUS_WIDTH-1:0] ls_req_addr,
    input  logic [BUS_WIDTH-1:0] ls_req_wmask,
    input  logic [BUS_WIDTH-1:0] ls_req_wdata,
    output logic                 ls_rsp_valid,
    output logic [BUS_WIDTH-1:0] ls_rsp_data,
    output logic                 ram_rd_en,
    output logic                 ram_wr_en,
    output logic [BUS_WIDTH-1:0] ram_addr,
    output logic [BUS_WIDTH-1:0] ram_wmask,
    output logic [BUS_WIDTH-1:0] ram_wr_data,
    input  logic [BUS_WIDTH-1:0] ram_rd_data
);

    arb_state_e state_q, state_d;
    logic       ls_we_q, ls_we_d;
    logic       grant_if, grant_ls;
    ram_req_t   ram_req;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // Remember who won last so the other side wins the next contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           last_grant <= ARB_ID_IF;
        else if (grant_if) last_grant <= ARB_ID_IF;
        else if (grant_ls) last_grant <= ARB_ID_LS;
    end
`else
    logic [CNT_W-1:0] starve_cnt;

    // Count LS wins that made a waiting IF lose; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_if)
            starve_cnt <= '0;
        else if (grant_ls && if_req_valid && starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + CNT_W'(1);
    end
`endif

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .state      (state_q),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant),
`else
        .starve_cnt (starve_cnt),
`endif
        .grant_if   (grant_if),
        .grant_ls   (grant_ls)
    );

    // State register; ls_we_q tells RESP_LS whether to return read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ls_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ls_we_q <= ls_we_d;
        end
    end

    // Next state, RAM issue and response steering.
    always_comb begin
        state_d      = state_q;
        ls_we_d      = ls_we_q;
        ram_req      = '0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = ZERO_WORD;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = ZERO_WORD;
        case (state_q)
            ARB_IDLE: begin
                if (grant_if) begin
                    state_d       = ARB_RESP_IF;
                    ram_req.rd_en = 1'b1;
                    ram_req.addr  = if_req_addr;
                end else if (grant_ls) begin
                    state_d      = ARB_RESP_LS;
                    ls_we_d      = ls_req_we;
                    ram_req.addr = ls_req_addr;
                    if (ls_req_we) begin
                        ram_req.wr_en = 1'b1;
                        ram_req.wmask = ls_req_wmask;
                        ram_req.wdata = ls_req_wdata;
                    end else begin
                        ram_req.rd_en = 1'b1;
                    end
                end
            end
            ARB_RESP_IF: begin
                state_d      = ARB_IDLE;
                if_rsp_valid = 1'b1;
                if_rsp_data  = ram_rd_data;
            end
            ARB_RESP_LS: begin
                state_d      = ARB_IDLE;
                ls_rsp_valid = 1'b1;
                ls_rsp_data  = ls_we_q ? ZERO_WORD : ram_rd_data;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    assign ram_rd_en   = ram_req.rd_en;
    assign ram_wr_en   = ram_req.wr_en;
    assign ram_addr    = ram_req.addr;
    assign ram_wmask   = ram_req.wmask;
    assign ram_wr_data = ram_req.wdata;

endmodule
